fetch_stage: RTL

Instruction fetch stage of the 5-stage RV32I pipeline; produces the {pc, instruction} pair consumed by the IF/ID register and, through it, the decode/control unit.
- Owns the PC register and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small in-order queue.
- Handles redirects from the EX-stage branch decision (br_sel) by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_stage_sva.sv | 22 ++
 rtl/fetch_stage.sv | 103 ++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory handshake, redirect and downstream signals of the fetch stage.
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        br_sel_i;
    logic [31:0] br_target_i;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;

    // Fetch stage side.
    modport master (
        output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, br_sel_i, br_target_i, stall_i
    );

    // Memory / pipeline environment side.
    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, br_sel_i, br_target_i, stall_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;

    // Qualify push/pop so the queue can never over- or underflow.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/fetch_stage_sva.sv
// Protocol and invariant checks for the fetch stage credit counters.
module fetch_stage_sva #(
    parameter int CNT_W = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             rvalid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] discard
);

    // A response with nothing outstanding is a memory protocol violation.
    rvalid_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_ni) rvalid |-> (outstanding != '0)
    );

    // Responses marked for dropping can never exceed those in flight.
    discard_bounded: assert property (
        @(posedge clk_i) disable iff (!rst_ni) discard <= outstanding
    );

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, credit-limited imem requests, response queue
// and redirect handling that drops responses still in flight.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input logic     clk_i,
    input logic     rst_ni,
    fetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pc_r;
    logic [31:0]      resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;

    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_empty_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;
    logic [CNT_W:0]   used_s;
    logic             req_s;
    logic             gnt_acc_s;
    logic             resp_s;
    logic             push_s;
    logic             valid_s;
    logic             pop_s;

    // Request credit, response acceptance and queue control.
    always_comb begin
        used_s       = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_s        = rst_ni && !bus.br_sel_i && (used_s < (CNT_W+1)'(DEPTH));
        gnt_acc_s    = req_s && bus.imem_gnt_i;
        // Stray responses with nothing outstanding are ignored.
        resp_s       = bus.imem_rvalid_i && (outstanding_r != '0);
        push_s       = resp_s && !bus.br_sel_i && (discard_r == '0);
        valid_s      = !fifo_empty_s && !bus.br_sel_i;
        pop_s        = valid_s && !bus.stall_i;
        push_entry_s = '{pc: resp_pc_r, instr: bus.imem_rdata_i};
    end

    // PC, response PC and outstanding/discard counters; redirect overrides all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else if (bus.br_sel_i) begin
            pc_r          <= align_word(bus.br_target_i);
            resp_pc_r     <= align_word(bus.br_target_i);
            outstanding_r <= outstanding_r - CNT_W'(resp_s);
            discard_r     <= outstanding_r - CNT_W'(resp_s);
        end else begin
            if (gnt_acc_s) begin
                pc_r <= pc_r + 32'd4;
            end
            // Responses return in order, so the pushed PC simply advances by a word.
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
            end
            if (resp_s && (discard_r != '0)) begin
                discard_r <= discard_r - CNT_W'(1);
            end
            outstanding_r <= outstanding_r + CNT_W'(gnt_acc_s) - CNT_W'(resp_s);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .pop    (pop_s),
        .flush  (bus.br_sel_i),
        .wdata  (push_entry_s),
        .rdata  (head_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    fetch_stage_sva #(
        .CNT_W (CNT_W)
    ) u_sva (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rvalid      (bus.imem_rvalid_i),
        .outstanding (outstanding_r),
        .discard     (discard_r)
    );

    assign bus.imem_req_o    = req_s;
    assign bus.imem_addr_o   = pc_r;
    assign bus.instr_valid_o = valid_s;
    assign bus.instr_o       = valid_s ? head_s.instr : NOP_INSTR;
    assign bus.pc_o          = valid_s ? head_s.pc : 32'h0000_0000;

endmodule
